ysyx_23060337_regwr_arb: RTL and testbench

Round-robin arbiter and sequencer for a single shared register-bank write port. It takes write requests from NREQ producers, such as the execute writeback, load return and CSR unit. Each cycle it grants at most one request and holds the winner in a one-entry output stage. That stage drives the bank's write enable, address and data. It sits between the producers and the register bank built from the team's flip-flop template, and it is the only block allowed to drive the bank's write port.

---
 rtl/ysyx_23060337_regwr_arb.sv | 109 ++++++++++
 tb/tb_ysyx_23060337_regwr_arb.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060337_regwr_arb.sv
// Round-robin arbiter feeding a one-entry output stage that owns the register bank write port.
// Requesters are searched upward from the one after the last accepted index.
module ysyx_23060337_regwr_arb #(
   parameter int NREQ  = 3,
   parameter int WIDTH = 32,
   parameter int AW    = 5,
   localparam int SW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*AW-1:0]    req_addr,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  wr_valid,
   output logic [AW-1:0]         wr_addr,
   output logic [WIDTH-1:0]      wr_data,
   input  logic                  wr_ready,
   output logic [SW-1:0]         wr_src
);

   logic             wr_valid_q, wr_valid_d;
   logic [AW-1:0]    wr_addr_q,  wr_addr_d;
   logic [WIDTH-1:0] wr_data_q,  wr_data_d;
   logic [SW-1:0]    wr_src_q,   wr_src_d;
   logic [SW-1:0]    last_q,     last_d;

   logic [NREQ-1:0]  hi_mask, req_hi, cand, grant;
   logic [SW-1:0]    win;
   logic             found;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_data;
   logic             free, accept;

   // Requests above `last` take precedence; otherwise wrap to the lowest set bit.
   always_comb begin
      hi_mask = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         hi_mask[i] = (i > 32'(last_q));
      end
      req_hi = req_valid & hi_mask;
      cand   = (|req_hi) ? req_hi : req_valid;
      grant  = '0;
      win    = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (cand[i] && !found) begin
            found    = 1'b1;
            grant[i] = 1'b1;
            win      = SW'(i);
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = req_addr[i*AW +: AW];
            sel_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // rst gates ready so nothing is accepted while the stage is held in reset.
   assign free      = !wr_valid_q || wr_ready;
   assign req_ready = (free && !rst) ? grant : '0;
   assign accept    = |(req_valid & req_ready);

   always_comb begin
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_src_d   = wr_src_q;
      last_d     = last_q;
      if (accept) begin
         wr_valid_d = 1'b1;
         wr_addr_d  = sel_addr;
         wr_data_d  = sel_data;
         wr_src_d   = win;
         last_d     = win;
      end else if (wr_ready) begin
         wr_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_src_q   <= '0;
         last_q     <= SW'(NREQ - 1);
      end else begin
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_src_q   <= wr_src_d;
         last_q     <= last_d;
      end
   end

   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_src   = wr_src_q;

endmodule

// File: tb/tb_ysyx_23060337_regwr_arb.sv
// Directed vector bench for the register write-port arbiter (NREQ=3, WIDTH=32, AW=5).
module tb_ysyx_23060337_regwr_arb;

   localparam int NREQ = 3;
   localparam int WIDTH = 32;
   localparam int AW = 5;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*AW-1:0]    req_addr;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  wr_valid;
   logic [AW-1:0]         wr_addr;
   logic [WIDTH-1:0]      wr_data;
   logic                  wr_ready;
   logic [1:0]            wr_src;

   int errors = 0;
   int checks = 0;

   logic [31:0] bank [32];

   ysyx_23060337_regwr_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .wr_src(wr_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_valid && wr_ready) bank[wr_addr] <= wr_data;
   end

   typedef struct packed {
      logic [2:0]       rv;
      logic [2:0][4:0]  a;
      logic [2:0][31:0] d;
      logic             wrdy;
      logic [2:0]       e_rdy;
      logic             e_v;
      logic [4:0]       e_a;
      logic [31:0]      e_d;
      logic [1:0]       e_src;
   } vec_t;

   function automatic vec_t mk(logic [2:0] rv, logic [4:0] a0, logic [4:0] a1, logic [4:0] a2,
                               logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic wrdy,
                               logic [2:0] erdy, logic ev, logic [4:0] ea, logic [31:0] ed,
                               logic [1:0] es);
      vec_t v;
      v.rv = rv; v.a = {a2, a1, a0}; v.d = {d2, d1, d0}; v.wrdy = wrdy;
      v.e_rdy = erdy; v.e_v = ev; v.e_a = ea; v.e_d = ed; v.e_src = es;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   localparam logic [31:0] D0 = 32'h1111_0000;
   localparam logic [31:0] D1 = 32'h2222_0000;
   localparam logic [31:0] D2 = 32'h3333_0000;
   localparam logic [31:0] D4 = 32'h4444_0000;
   localparam logic [31:0] D5 = 32'h5555_0000;

   vec_t tv [20];
   logic [2:0] rr_rdy [6];
   logic [1:0] rr_src [6];

   initial begin
      rr_rdy = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
      rr_src = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
      // Single request to requester 1 and an idle drain.
      tv[0] = mk(3'b010, 0, 7, 0, 0, 32'hDEADBEEF, 0, 1'b1, 3'b010, 1'b1, 7, 32'hDEADBEEF, 2'd1);
      tv[1] = mk(3'b000, 0, 7, 0, 0, 32'hDEADBEEF, 0, 1'b1, 3'b000, 1'b0, 7, 32'hDEADBEEF, 2'd1);
      // Round robin with all three valid, pointer starts at 1.
      for (int i = 0; i < 6; i++) begin
         tv[2+i] = mk(3'b111, 1, 2, 3, D0, D1, D2, 1'b1, rr_rdy[i], 1'b1,
                      5'(rr_src[i] + 2'd1), (rr_src[i] == 2'd0) ? D0 : (rr_src[i] == 2'd1) ? D1 : D2,
                      rr_src[i]);
      end
      // Backpressure: addr 3 held for 4 cycles while req 2 waits.
      tv[8] = mk(3'b100, 0, 0, 3, 0, 0, D2, 1'b1, 3'b100, 1'b1, 3, D2, 2'd2);
      for (int i = 9; i <= 12; i++) begin
         tv[i] = mk(3'b100, 0, 0, 4, 0, 0, D4, 1'b0, 3'b000, 1'b1, 3, D2, 2'd2);
      end
      tv[13] = mk(3'b100, 0, 0, 4, 0, 0, D4, 1'b1, 3'b100, 1'b1, 4, D4, 2'd2);
      // Pointer wrap from last=2 with 3'b101.
      tv[14] = mk(3'b101, 1, 0, 5, D0, 0, D5, 1'b1, 3'b001, 1'b1, 1, D0, 2'd0);
      tv[15] = mk(3'b100, 0, 0, 5, 0, 0, D5, 1'b1, 3'b100, 1'b1, 5, D5, 2'd2);
      // Same address from requesters 0 and 1.
      tv[16] = mk(3'b011, 9, 9, 0, 1, 2, 0, 1'b1, 3'b001, 1'b1, 9, 1, 2'd0);
      tv[17] = mk(3'b010, 0, 9, 0, 0, 2, 0, 1'b1, 3'b010, 1'b1, 9, 2, 2'd1);
      tv[18] = mk(3'b000, 0, 0, 0, 0, 0, 0, 1'b1, 3'b000, 1'b0, 9, 2, 2'd1);
      // Empty stage accepts even with wr_ready low.
      tv[19] = mk(3'b001, 10, 0, 0, 32'hAAAA, 0, 0, 1'b0, 3'b001, 1'b1, 10, 32'hAAAA, 2'd0);

      rst = 1'b1;
      req_valid = 3'b111;
      req_addr = {5'd3, 5'd2, 5'd1};
      req_data = {D2, D1, D0};
      wr_ready = 1'b1;
      #1;
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_valid", 32'(wr_valid), 32'd0);
      chk("reset_addr", 32'(wr_addr), 32'd0);
      chk("reset_data", wr_data, 32'd0);
      chk("reset_src", 32'(wr_src), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         req_valid = tv[i].rv;
         req_addr  = tv[i].a;
         req_data  = tv[i].d;
         wr_ready  = tv[i].wrdy;
         #1;
         chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tv[i].e_rdy));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_wr_valid", i), 32'(wr_valid), 32'(tv[i].e_v));
         chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tv[i].e_a));
         chk($sformatf("v%0d_wr_data", i), wr_data, tv[i].e_d);
         chk($sformatf("v%0d_wr_src", i), 32'(wr_src), 32'(tv[i].e_src));
      end
      chk("bank_addr9_last_write", bank[9], 32'd2);

      // Async reset between edges during continuous traffic.
      @(negedge clk);
      req_valid = 3'b111;
      req_addr  = {5'd3, 5'd2, 5'd1};
      req_data  = {D2, D1, D0};
      wr_ready  = 1'b1;
      @(posedge clk);
      #1;
      chk("burst_pre_valid", 32'(wr_valid), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(wr_valid), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd0);
      chk("midrst_data", wr_data, 32'd0);
      chk("midrst_src", 32'(wr_src), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("postrst_ready", 32'(req_ready), 32'b001);
      @(posedge clk);
      #1;
      chk("postrst_valid", 32'(wr_valid), 32'd1);
      chk("postrst_src", 32'(wr_src), 32'd0);
      chk("postrst_addr", 32'(wr_addr), 32'd1);
      chk("postrst_data", wr_data, D0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
